// File: rtl/decode_pkg.sv
// Shared RV32I decode definitions: opcodes, function codes, ALU one-hot indices,
// immediate formats and the control bundle carried from ID to EX.
package decode_pkg;

    localparam logic [6:0] OP_LUI      = 7'b0110111;
    localparam logic [6:0] OP_AUIPC    = 7'b0010111;
    localparam logic [6:0] OP_JAL      = 7'b1101111;
    localparam logic [6:0] OP_JALR     = 7'b1100111;
    localparam logic [6:0] OP_BRANCH   = 7'b1100011;
    localparam logic [6:0] OP_LOAD     = 7'b0000011;
    localparam logic [6:0] OP_STORE    = 7'b0100011;
    localparam logic [6:0] OP_IMM      = 7'b0010011;
    localparam logic [6:0] OP_REG      = 7'b0110011;
    localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
    localparam logic [6:0] OP_SYSTEM   = 7'b1110011;

    localparam logic [2:0] F3_ADD  = 3'b000;
    localparam logic [2:0] F3_SLL  = 3'b001;
    localparam logic [2:0] F3_SLT  = 3'b010;
    localparam logic [2:0] F3_SLTU = 3'b011;
    localparam logic [2:0] F3_XOR  = 3'b100;
    localparam logic [2:0] F3_SR   = 3'b101;
    localparam logic [2:0] F3_OR   = 3'b110;

    localparam logic [6:0] F7_BASE   = 7'b0000000;
    localparam logic [6:0] F7_ALT    = 7'b0100000;
    localparam logic [6:0] F7_MULDIV = 7'b0000001;

    localparam logic [31:0] INSTR_ECALL  = 32'h0000_0073;
    localparam logic [31:0] INSTR_EBREAK = 32'h0010_0073;

    localparam int unsigned ALU_ADD    = 0;
    localparam int unsigned ALU_SUB    = 1;
    localparam int unsigned ALU_SLL    = 2;
    localparam int unsigned ALU_SLT    = 3;
    localparam int unsigned ALU_SLTU   = 4;
    localparam int unsigned ALU_XOR    = 5;
    localparam int unsigned ALU_SRL    = 6;
    localparam int unsigned ALU_SRA    = 7;
    localparam int unsigned ALU_OR     = 8;
    localparam int unsigned ALU_AND    = 9;
    localparam int unsigned ALU_LUI    = 10;
    localparam int unsigned ALU_MUL    = 11;
    localparam int unsigned ALU_MULH   = 12;
    localparam int unsigned ALU_MULHSU = 13;
    localparam int unsigned ALU_MULHU  = 14;
    localparam int unsigned ALU_DIV    = 15;
    localparam int unsigned ALU_DIVU   = 16;
    localparam int unsigned ALU_REM    = 17;
    localparam int unsigned ALU_REMU   = 18;
    localparam int unsigned ALU_FUN_MAX = 19;

    localparam logic [1:0] OP2_RS2 = 2'b00;
    localparam logic [1:0] OP2_IMM = 2'b01;
    localparam logic [1:0] OP2_PC  = 2'b10;

    localparam logic [1:0] WR_ALU = 2'b00;
    localparam logic [1:0] WR_MEM = 2'b01;
    localparam logic [1:0] WR_PC4 = 2'b10;

    typedef enum logic [2:0] {
        IMM_NONE,
        IMM_I,
        IMM_S,
        IMM_B,
        IMM_U,
        IMM_J
    } imm_fmt_e;

    typedef struct packed {
        logic [ALU_FUN_MAX-1:0] alu_fun;
        logic                   alu_op1_sel;
        logic [1:0]             alu_op2_sel;
        logic                   reg_wr_en;
        logic [1:0]             reg_wr_sel;
        logic                   dmem_rd_en;
        logic                   dmem_wr_en;
        logic [1:0]             dmem_size;
        logic                   dmem_sign;
        logic                   rs1_used;
        logic                   rs2_used;
        logic                   instr_jal;
        logic                   instr_jalr;
        logic                   instr_branch;
        logic                   ecall;
        logic                   ebreak;
        logic                   illegal;
    } id_ctrl_t;

    function automatic logic [ALU_FUN_MAX-1:0] alu_onehot(input int unsigned idx);
        logic [ALU_FUN_MAX-1:0] one;
        one = {{(ALU_FUN_MAX-1){1'b0}}, 1'b1};
        return one << idx;
    endfunction

    // Base integer function from funct3; alt selects SUB/SRA on the shared codes.
    function automatic int unsigned base_alu_idx(input logic [2:0] funct3, input logic alt);
        int unsigned idx;
        case (funct3)
            F3_ADD:  idx = alt ? ALU_SUB : ALU_ADD;
            F3_SLL:  idx = ALU_SLL;
            F3_SLT:  idx = ALU_SLT;
            F3_SLTU: idx = ALU_SLTU;
            F3_XOR:  idx = ALU_XOR;
            F3_SR:   idx = alt ? ALU_SRA : ALU_SRL;
            F3_OR:   idx = ALU_OR;
            default: idx = ALU_AND;
        endcase
        return idx;
    endfunction

    function automatic logic [31:0] imm_gen(input logic [31:0] instr, input imm_fmt_e fmt);
        logic [31:0] imm;
        case (fmt)
            IMM_I:   imm = {{20{instr[31]}}, instr[31:20]};
            IMM_S:   imm = {{20{instr[31]}}, instr[31:25], instr[11:7]};
            IMM_B:   imm = {{19{instr[31]}}, instr[31], instr[7], instr[30:25], instr[11:8], 1'b0};
            IMM_U:   imm = {instr[31:12], 12'b0};
            IMM_J:   imm = {{11{instr[31]}}, instr[31], instr[19:12], instr[20], instr[30:21], 1'b0};
            default: imm = '0;
        endcase
        return imm;
    endfunction

endpackage

// File: rtl/pipe_skid_buffer.sv
// Generic 2-entry valid/ready pipeline register with flush. The ready output
// is a flop, so upstream never sees a combinational path from out_ready_i.
module pipe_skid_buffer #(
    parameter int WIDTH = 8
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             flush_i,
    input  logic             in_valid_i,
    output logic             in_ready_o,
    input  logic [WIDTH-1:0] in_data_i,
    output logic             out_valid_o,
    input  logic             out_ready_i,
    output logic [WIDTH-1:0] out_data_o
);

    logic             main_valid_q, main_valid_d;
    logic             skid_valid_q, skid_valid_d;
    logic             ready_q, ready_d;
    logic [WIDTH-1:0] main_data_q, main_data_d;
    logic [WIDTH-1:0] skid_data_q, skid_data_d;
    logic             accept;
    logic             pop;

    assign accept = in_valid_i && ready_q;
    assign pop    = main_valid_q && out_ready_i;

    always_comb begin
        // NOTE: every variable gets its hold value first, so no branch can leave it unassigned and infer a latch.
        main_valid_d = main_valid_q;
        main_data_d  = main_data_q;
        skid_valid_d = skid_valid_q;
        skid_data_d  = skid_data_q;

        if (skid_valid_q) begin
            // Full: ready is low, so only a drain of the older entry can happen.
            if (pop) begin
                main_data_d  = skid_data_q;
                skid_valid_d = 1'b0;
            end
        end else if (main_valid_q && !pop) begin
            if (accept) begin
                skid_data_d  = in_data_i;
                skid_valid_d = 1'b1;
            end
        end else begin
            main_valid_d = accept;
            if (accept) begin
                main_data_d = in_data_i;
            end
        end

        if (flush_i) begin
            main_valid_d = 1'b0;
            skid_valid_d = 1'b0;
        end

        ready_d = !skid_valid_d;
    end

    always_ff @(posedge clk_i) begin
        // NOTE: payload flops are reset as well, because reset must drive every downstream output to zero.
        if (rst_i) begin
            main_valid_q <= 1'b0;
            skid_valid_q <= 1'b0;
            ready_q      <= 1'b1;
            main_data_q  <= '0;
            skid_data_q  <= '0;
        end else begin
            // NOTE: non-blocking assignments make every flop sample pre-edge values regardless of statement order.
            main_valid_q <= main_valid_d;
            skid_valid_q <= skid_valid_d;
            ready_q      <= ready_d;
            main_data_q  <= main_data_d;
            skid_data_q  <= skid_data_d;
        end
    end

    assign in_ready_o  = ready_q;
    assign out_valid_o = main_valid_q;
    assign out_data_o  = main_data_q;

endmodule

// File: rtl/decode_stage.sv
// RV32I(+M) instruction decode stage: combinational decode into a control
// bundle, registered through a 2-entry skid buffer towards EX.
module decode_stage
    import decode_pkg::*;
#(
    parameter int  XLEN      = 32,
    parameter int  ENABLE_M  = 0,
    localparam int ALU_FUN_W = 11 + 8 * ENABLE_M
) (
    input  logic                 clk_i,
    input  logic                 rst_i,
    input  logic                 flush_i,
    input  logic                 if_valid_i,
    output logic                 if_ready_o,
    input  logic [31:0]          instr_i,
    input  logic [XLEN-1:0]      pc_i,
    output logic                 id_valid_o,
    input  logic                 id_ready_i,
    output logic [XLEN-1:0]      pc_o,
    output logic [XLEN-1:0]      imm_o,
    output logic [4:0]           rs1_o,
    output logic [4:0]           rs2_o,
    output logic [4:0]           rd_o,
    output logic                 rs1_used_o,
    output logic                 rs2_used_o,
    output logic [ALU_FUN_W-1:0] alu_fun_o,
    output logic                 alu_op1_sel_o,
    output logic [1:0]           alu_op2_sel_o,
    output logic                 reg_wr_en_o,
    output logic [1:0]           reg_wr_sel_o,
    output logic                 dmem_rd_en_o,
    output logic                 dmem_wr_en_o,
    output logic [1:0]           dmem_size_o,
    output logic                 dmem_sign_o,
    output logic                 instr_jal_o,
    output logic                 instr_jalr_o,
    output logic                 instr_branch_o,
    output logic                 ecall_o,
    output logic                 ebreak_o,
    output logic                 illegal_o
);

    localparam int PAYLOAD_W = $bits(id_ctrl_t) + 2 * XLEN + 15;

    logic [6:0]           opcode;
    logic [2:0]           funct3;
    logic [6:0]           funct7;
    id_ctrl_t             ctrl_d, ctrl_q;
    imm_fmt_e             imm_fmt;
    logic                 illegal;
    logic [XLEN-1:0]      imm_d;
    logic [PAYLOAD_W-1:0] payload_d, payload_q;

    assign opcode = instr_i[6:0];
    assign funct3 = instr_i[14:12];
    assign funct7 = instr_i[31:25];

    always_comb begin
        ctrl_d  = '0;
        imm_fmt = IMM_NONE;
        illegal = 1'b0;

        case (opcode)
            OP_LUI: begin
                imm_fmt             = IMM_U;
                ctrl_d.alu_fun      = alu_onehot(ALU_LUI);
                ctrl_d.alu_op1_sel  = 1'b1;
                ctrl_d.reg_wr_en    = 1'b1;
            end
            OP_AUIPC: begin
                imm_fmt             = IMM_U;
                ctrl_d.alu_fun      = alu_onehot(ALU_ADD);
                ctrl_d.alu_op1_sel  = 1'b1;
                ctrl_d.alu_op2_sel  = OP2_PC;
                ctrl_d.reg_wr_en    = 1'b1;
            end
            OP_JAL: begin
                // ALU forms the target pc+imm; rd receives pc+4.
                imm_fmt             = IMM_J;
                ctrl_d.alu_fun      = alu_onehot(ALU_ADD);
                ctrl_d.alu_op1_sel  = 1'b1;
                ctrl_d.alu_op2_sel  = OP2_PC;
                ctrl_d.reg_wr_en    = 1'b1;
                ctrl_d.reg_wr_sel   = WR_PC4;
                ctrl_d.instr_jal    = 1'b1;
            end
            OP_JALR: begin
                imm_fmt             = IMM_I;
                illegal             = (funct3 != 3'd0);
                ctrl_d.alu_fun      = alu_onehot(ALU_ADD);
                ctrl_d.alu_op2_sel  = OP2_IMM;
                ctrl_d.reg_wr_en    = 1'b1;
                ctrl_d.reg_wr_sel   = WR_PC4;
                ctrl_d.rs1_used     = 1'b1;
                ctrl_d.instr_jalr   = 1'b1;
            end
            OP_BRANCH: begin
                // EX recovers the full funct3 from {!dmem_sign, dmem_size}.
                imm_fmt             = IMM_B;
                illegal             = (funct3 == 3'd2) || (funct3 == 3'd3);
                ctrl_d.dmem_size    = funct3[1:0];
                ctrl_d.dmem_sign    = !funct3[2];
                ctrl_d.rs1_used     = 1'b1;
                ctrl_d.rs2_used     = 1'b1;
                ctrl_d.instr_branch = 1'b1;
            end
            OP_LOAD: begin
                imm_fmt             = IMM_I;
                illegal             = (funct3 == 3'd3) || (funct3 >= 3'd6);
                ctrl_d.alu_fun      = alu_onehot(ALU_ADD);
                ctrl_d.alu_op2_sel  = OP2_IMM;
                ctrl_d.reg_wr_en    = 1'b1;
                ctrl_d.reg_wr_sel   = WR_MEM;
                ctrl_d.dmem_rd_en   = 1'b1;
                ctrl_d.dmem_size    = funct3[1:0];
                ctrl_d.dmem_sign    = !funct3[2];
                ctrl_d.rs1_used     = 1'b1;
            end
            OP_STORE: begin
                imm_fmt             = IMM_S;
                illegal             = (funct3 > 3'd2);
                ctrl_d.alu_fun      = alu_onehot(ALU_ADD);
                ctrl_d.alu_op2_sel  = OP2_IMM;
                ctrl_d.dmem_wr_en   = 1'b1;
                ctrl_d.dmem_size    = funct3[1:0];
                ctrl_d.dmem_sign    = !funct3[2];
                ctrl_d.rs1_used     = 1'b1;
                ctrl_d.rs2_used     = 1'b1;
            end
            OP_IMM: begin
                // Shift immediates reuse imm[11:5] as funct7.
                imm_fmt             = IMM_I;
                if (funct3 == F3_SLL) begin
                    illegal = (funct7 != F7_BASE);
                end else if (funct3 == F3_SR) begin
                    illegal = (funct7 != F7_BASE) && (funct7 != F7_ALT);
                end
                ctrl_d.alu_fun      = alu_onehot(base_alu_idx(funct3, (funct3 == F3_SR) && (funct7 == F7_ALT)));
                ctrl_d.alu_op2_sel  = OP2_IMM;
                ctrl_d.reg_wr_en    = 1'b1;
                ctrl_d.rs1_used     = 1'b1;
            end
            OP_REG: begin
                if (funct7 == F7_BASE) begin
                    ctrl_d.alu_fun = alu_onehot(base_alu_idx(funct3, 1'b0));
                end else if ((funct7 == F7_ALT) && ((funct3 == F3_ADD) || (funct3 == F3_SR))) begin
                    ctrl_d.alu_fun = alu_onehot(base_alu_idx(funct3, 1'b1));
                end else if ((funct7 == F7_MULDIV) && (ENABLE_M != 0)) begin
                    ctrl_d.alu_fun = alu_onehot(ALU_MUL + 32'(funct3));
                end else begin
                    illegal = 1'b1;
                end
                ctrl_d.reg_wr_en    = 1'b1;
                ctrl_d.rs1_used     = 1'b1;
                ctrl_d.rs2_used     = 1'b1;
            end
            OP_MISC_MEM: begin
            end
            OP_SYSTEM: begin
                if (instr_i == INSTR_ECALL) begin
                    ctrl_d.ecall = 1'b1;
                end else if (instr_i == INSTR_EBREAK) begin
                    ctrl_d.ebreak = 1'b1;
                end else begin
                    illegal = 1'b1;
                end
            end
            default: illegal = 1'b1;
        endcase

        if (illegal) begin
            ctrl_d         = '0;
            ctrl_d.illegal = 1'b1;
        end

        imm_d = XLEN'($signed(imm_gen(instr_i, imm_fmt)));
    end

    assign payload_d = {ctrl_d, pc_i, imm_d, instr_i[19:15], instr_i[24:20], instr_i[11:7]};

    pipe_skid_buffer #(
        .WIDTH(PAYLOAD_W)
    ) u_skid (
        .clk_i      (clk_i),
        .rst_i      (rst_i),
        .flush_i    (flush_i),
        .in_valid_i (if_valid_i),
        .in_ready_o (if_ready_o),
        .in_data_i  (payload_d),
        .out_valid_o(id_valid_o),
        .out_ready_i(id_ready_i),
        .out_data_o (payload_q)
    );

    assign {ctrl_q, pc_o, imm_o, rs1_o, rs2_o, rd_o} = payload_q;

    assign alu_fun_o      = ALU_FUN_W'(ctrl_q.alu_fun);
    assign alu_op1_sel_o  = ctrl_q.alu_op1_sel;
    assign alu_op2_sel_o  = ctrl_q.alu_op2_sel;
    assign reg_wr_en_o    = ctrl_q.reg_wr_en;
    assign reg_wr_sel_o   = ctrl_q.reg_wr_sel;
    assign dmem_rd_en_o   = ctrl_q.dmem_rd_en;
    assign dmem_wr_en_o   = ctrl_q.dmem_wr_en;
    assign dmem_size_o    = ctrl_q.dmem_size;
    assign dmem_sign_o    = ctrl_q.dmem_sign;
    assign rs1_used_o     = ctrl_q.rs1_used;
    assign rs2_used_o     = ctrl_q.rs2_used;
    assign instr_jal_o    = ctrl_q.instr_jal;
    assign instr_jalr_o   = ctrl_q.instr_jalr;
    assign instr_branch_o = ctrl_q.instr_branch;
    assign ecall_o        = ctrl_q.ecall;
    assign ebreak_o       = ctrl_q.ebreak;
    assign illegal_o      = ctrl_q.illegal;

`ifdef FORMAL
    always_comb begin
        assert ($onehot0(alu_fun_o));
        assert (!(dmem_rd_en_o && dmem_wr_en_o));
        assert ($onehot0({instr_jal_o, instr_jalr_o, instr_branch_o, ecall_o, ebreak_o, illegal_o}));
    end
`endif

endmodule
